lazy_select_pipeline: RTL and testbench

Parametrised, flow-controlled successor to the lazy summary stage in the match engine. It takes one lazy-match window per transfer: `LAZY_LEN` candidate matches starting at consecutive positions. It scores each candidate, selects the best one and converts it into a sequence summary (literal length, match length, offset, end-of-job and overlap info) for the sequence writer. Compared with the previous stage, it adds:
- valid/ready backpressure;
- asynchronous reset;
- a per-request greedy/lazy mode;
- a minimum-match-length filter;
- a no-match path;
- statistics counters.

---
 rtl/lazy_select_pipeline.sv | 253 +++++++++++++++++++++++++
 tb/tb_lazy_select_pipeline.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lazy_select_pipeline.sv
// Lazy-match window selector: scores each candidate slot, picks the best and
// emits a sequence summary through a three-stage valid/ready pipeline.
module lazy_select_pipeline #(
    parameter int unsigned LAZY_LEN        = 4,
    parameter int unsigned JOB_LEN_LOG2    = 5,
    parameter int unsigned MATCH_LEN_WIDTH = 8,
    parameter int unsigned SEQ_OFFSET_BITS = 16,
    parameter int unsigned SEQ_LL_BITS     = 8,
    parameter int unsigned SEQ_ML_BITS     = 8,
    parameter int unsigned GAIN_BITS       = 16,
    parameter int unsigned LIT_COST        = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [JOB_LEN_LOG2-1:0]               i_seq_head_ptr,
    input  logic [JOB_LEN_LOG2-1:0]               i_match_head_ptr,
    input  logic                                  i_delim,
    input  logic                                  i_greedy,
    input  logic [MATCH_LEN_WIDTH-1:0]            i_min_ml,
    input  logic [LAZY_LEN-1:0]                   i_match_valid,
    input  logic [LAZY_LEN*MATCH_LEN_WIDTH-1:0]   i_match_len,
    input  logic [LAZY_LEN*SEQ_OFFSET_BITS-1:0]   i_offset,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [JOB_LEN_LOG2-1:0]               o_seq_head_ptr,
    output logic [SEQ_LL_BITS-1:0]                o_ll,
    output logic [SEQ_ML_BITS-1:0]                o_ml,
    output logic [SEQ_OFFSET_BITS-1:0]            o_offset,
    output logic                                  o_nomatch,
    output logic                                  o_delim,
    output logic                                  o_eoj,
    output logic [SEQ_ML_BITS-1:0]                o_overlap_len,
    output logic                                  o_move_to_next_job,
    output logic [JOB_LEN_LOG2-1:0]               o_move_forward,
    output logic [31:0]                           o_stat_seq_cnt,
    output logic [31:0]                           o_stat_job_cnt
);
    localparam int unsigned JOB_LEN = 1 << JOB_LEN_LOG2;
    localparam int unsigned LLW     = JOB_LEN_LOG2 + 1;
    localparam int unsigned MW      = MATCH_LEN_WIDTH;
    localparam int unsigned MFW     = MATCH_LEN_WIDTH + 1;
    localparam int unsigned OVW     = MATCH_LEN_WIDTH + 2;
    localparam int unsigned OW      = SEQ_OFFSET_BITS;
    localparam int unsigned OBW     = $clog2(SEQ_OFFSET_BITS + 1);
    localparam int unsigned IW      = (LAZY_LEN > 1) ? $clog2(LAZY_LEN) : 1;

    // Flow control: a stage loads when empty or drained this cycle
    logic s0_v_q, s1_v_q, s2_v_q, s0_v_d, s1_v_d, s2_v_d;
    logic s0_rdy, s1_rdy, s2_rdy, s0_ld, s1_ld, s2_ld, xfer;

    assign s2_rdy  = ~s2_v_q | i_ready;
    assign s1_rdy  = ~s1_v_q | s2_rdy;
    assign s0_rdy  = ~s0_v_q | s1_rdy;
    assign s0_ld   = i_valid & s0_rdy;
    assign s1_ld   = s0_v_q & s1_rdy;
    assign s2_ld   = s1_v_q & s2_rdy;
    assign xfer    = s2_v_q & i_ready;
    assign o_ready = s0_rdy;

    always_comb begin
        s0_v_d = s0_ld | (s0_v_q & ~s1_rdy);
        s1_v_d = s1_ld | (s1_v_q & ~s2_rdy);
        s2_v_d = s2_ld | (s2_v_q & ~i_ready);
    end

    // Stage 0: literal lengths, offset bit counts and eligibility
    logic [JOB_LEN_LOG2-1:0]               s0_seq_q, s0_seq_d;
    logic                                  s0_delim_q, s0_delim_d;
    logic [LAZY_LEN-1:0]                   s0_elig_q, s0_elig_d;
    logic [LAZY_LEN-1:0][LLW-1:0]          s0_ll_q, s0_ll_d;
    logic [LAZY_LEN-1:0][OBW-1:0]          s0_obits_q, s0_obits_d;
    logic [LAZY_LEN-1:0][MW-1:0]           s0_ml_q, s0_ml_d;
    logic [LAZY_LEN-1:0][OW-1:0]           s0_off_q, s0_off_d;

    always_comb begin
        s0_seq_d   = s0_seq_q;
        s0_delim_d = s0_delim_q;
        s0_elig_d  = s0_elig_q;
        s0_ll_d    = s0_ll_q;
        s0_obits_d = s0_obits_q;
        s0_ml_d    = s0_ml_q;
        s0_off_d   = s0_off_q;
        if (s0_ld) begin
            s0_seq_d   = i_seq_head_ptr;
            s0_delim_d = i_delim;
            for (int i = 0; i < LAZY_LEN; i++) begin
                s0_ml_d[i]    = i_match_len[i*MW +: MW];
                s0_off_d[i]   = i_offset[i*OW +: OW];
                s0_ll_d[i]    = LLW'(i_match_head_ptr) - LLW'(i_seq_head_ptr) + LLW'(i);
                s0_obits_d[i] = '0;
                for (int b = 0; b < OW; b++) begin
                    if (i_offset[i*OW + b]) s0_obits_d[i] = OBW'(b + 1);
                end
                s0_elig_d[i]  = i_match_valid[i] && (i_match_len[i*MW +: MW] >= i_min_ml)
                                && (!i_greedy || i == 0);
            end
        end
    end

    // Stage 1: gain and match-end position per slot
    logic [JOB_LEN_LOG2-1:0]               s1_seq_q, s1_seq_d;
    logic                                  s1_delim_q, s1_delim_d;
    logic [LAZY_LEN-1:0]                   s1_elig_q, s1_elig_d;
    logic [LAZY_LEN-1:0][LLW-1:0]          s1_ll_q, s1_ll_d;
    logic [LAZY_LEN-1:0][GAIN_BITS-1:0]    s1_gain_q, s1_gain_d;
    logic [LAZY_LEN-1:0][MFW-1:0]          s1_mf_q, s1_mf_d;
    logic [LAZY_LEN-1:0][MW-1:0]           s1_ml_q, s1_ml_d;
    logic [LAZY_LEN-1:0][OW-1:0]           s1_off_q, s1_off_d;

    always_comb begin
        s1_seq_d   = s1_seq_q;
        s1_delim_d = s1_delim_q;
        s1_elig_d  = s1_elig_q;
        s1_ll_d    = s1_ll_q;
        s1_gain_d  = s1_gain_q;
        s1_mf_d    = s1_mf_q;
        s1_ml_d    = s1_ml_q;
        s1_off_d   = s1_off_q;
        if (s1_ld) begin
            s1_seq_d   = s0_seq_q;
            s1_delim_d = s0_delim_q;
            s1_elig_d  = s0_elig_q;
            s1_ll_d    = s0_ll_q;
            s1_ml_d    = s0_ml_q;
            s1_off_d   = s0_off_q;
            for (int i = 0; i < LAZY_LEN; i++) begin
                s1_gain_d[i] = (GAIN_BITS'(s0_ml_q[i]) << 2)
                             + GAIN_BITS'(LIT_COST * (LAZY_LEN - i))
                             - GAIN_BITS'(s0_obits_q[i]);
                s1_mf_d[i]   = MFW'(s0_ml_q[i]) + MFW'(s0_ll_q[i]);
            end
        end
    end

    // Stage 2: winner selection and job-end handling
    logic [JOB_LEN_LOG2-1:0]   seq_q, seq_d, mvf_q, mvf_d;
    logic [SEQ_LL_BITS-1:0]    ll_q, ll_d;
    logic [SEQ_ML_BITS-1:0]    ml_q, ml_d, ovl_q, ovl_d;
    logic [OW-1:0]             off_q, off_d;
    logic                      nm_q, nm_d, delim_q, delim_d, eoj_q, eoj_d, mtnj_q, mtnj_d;
    logic [31:0]               seq_cnt_q, seq_cnt_d, job_cnt_q, job_cnt_d;

    logic                      found;
    logic [IW-1:0]             win;
    logic [GAIN_BITS-1:0]      best;
    logic [LLW-1:0]            sel_ll;
    logic [MW-1:0]             sel_ml;
    logic [OW-1:0]             sel_off;
    logic [MFW-1:0]            sel_mf;
    logic [OVW-1:0]            ov;

    always_comb begin
        found = 1'b0;
        win   = '0;
        best  = '0;
        for (int i = 0; i < LAZY_LEN; i++) begin
            // Strict compare keeps ties on the lowest slot
            if (s1_elig_q[i] && (!found || $signed(s1_gain_q[i]) > $signed(best))) begin
                found = 1'b1;
                win   = IW'(i);
                best  = s1_gain_q[i];
            end
        end
        sel_ll  = found ? s1_ll_q[win]  : '0;
        sel_ml  = found ? s1_ml_q[win]  : '0;
        sel_off = found ? s1_off_q[win] : '0;
        sel_mf  = found ? s1_mf_q[win]  : MFW'(s1_ll_q[0]) + MFW'(LAZY_LEN);
        ov      = OVW'(s1_seq_q) + OVW'(sel_mf) - OVW'(JOB_LEN);

        seq_d   = seq_q;
        ll_d    = ll_q;
        ml_d    = ml_q;
        off_d   = off_q;
        nm_d    = nm_q;
        delim_d = delim_q;
        eoj_d   = eoj_q;
        mtnj_d  = mtnj_q;
        ovl_d   = ovl_q;
        mvf_d   = mvf_q;
        if (s2_ld) begin
            seq_d   = s1_seq_q;
            nm_d    = ~found;
            delim_d = s1_delim_q;
            if (ov[OVW-1]) begin
                ll_d   = SEQ_LL_BITS'(sel_ll);
                ml_d   = SEQ_ML_BITS'(sel_ml);
                off_d  = sel_off;
                eoj_d  = 1'b0;
                mtnj_d = 1'b0;
                ovl_d  = '0;
                mvf_d  = sel_mf[JOB_LEN_LOG2-1:0];
            end else if (s1_delim_q || !found) begin
                ll_d   = SEQ_LL_BITS'(LLW'(JOB_LEN) - LLW'(s1_seq_q));
                ml_d   = '0;
                off_d  = '0;
                eoj_d  = 1'b1;
                mtnj_d = 1'b1;
                ovl_d  = '0;
                mvf_d  = '0;
            end else begin
                ll_d   = SEQ_LL_BITS'(sel_ll);
                ml_d   = SEQ_ML_BITS'(sel_ml);
                off_d  = sel_off;
                eoj_d  = 1'b1;
                mtnj_d = 1'b1;
                ovl_d  = ov[SEQ_ML_BITS-1:0];
                mvf_d  = '0;
            end
        end
        seq_cnt_d = seq_cnt_q + 32'(xfer & ~nm_q);
        job_cnt_d = job_cnt_q + 32'(xfer & eoj_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v_q <= 1'b0;  s1_v_q <= 1'b0;  s2_v_q <= 1'b0;
            s0_seq_q <= '0;  s0_delim_q <= 1'b0; s0_elig_q <= '0; s0_ll_q <= '0;
            s0_obits_q <= '0; s0_ml_q <= '0; s0_off_q <= '0;
            s1_seq_q <= '0;  s1_delim_q <= 1'b0; s1_elig_q <= '0; s1_ll_q <= '0;
            s1_gain_q <= '0; s1_mf_q <= '0; s1_ml_q <= '0; s1_off_q <= '0;
            seq_q <= '0; ll_q <= '0; ml_q <= '0; off_q <= '0; nm_q <= 1'b0;
            delim_q <= 1'b0; eoj_q <= 1'b0; mtnj_q <= 1'b0; ovl_q <= '0; mvf_q <= '0;
            seq_cnt_q <= '0; job_cnt_q <= '0;
        end else begin
            s0_v_q <= s0_v_d;  s1_v_q <= s1_v_d;  s2_v_q <= s2_v_d;
            s0_seq_q <= s0_seq_d;  s0_delim_q <= s0_delim_d; s0_elig_q <= s0_elig_d;
            s0_ll_q <= s0_ll_d; s0_obits_q <= s0_obits_d; s0_ml_q <= s0_ml_d; s0_off_q <= s0_off_d;
            s1_seq_q <= s1_seq_d;  s1_delim_q <= s1_delim_d; s1_elig_q <= s1_elig_d;
            s1_ll_q <= s1_ll_d; s1_gain_q <= s1_gain_d; s1_mf_q <= s1_mf_d;
            s1_ml_q <= s1_ml_d; s1_off_q <= s1_off_d;
            seq_q <= seq_d; ll_q <= ll_d; ml_q <= ml_d; off_q <= off_d; nm_q <= nm_d;
            delim_q <= delim_d; eoj_q <= eoj_d; mtnj_q <= mtnj_d; ovl_q <= ovl_d; mvf_q <= mvf_d;
            seq_cnt_q <= seq_cnt_d; job_cnt_q <= job_cnt_d;
        end
    end

    assign o_valid            = s2_v_q;
    assign o_seq_head_ptr     = seq_q;
    assign o_ll               = ll_q;
    assign o_ml               = ml_q;
    assign o_offset           = off_q;
    assign o_nomatch          = nm_q;
    assign o_delim            = delim_q;
    assign o_eoj              = eoj_q;
    assign o_overlap_len      = ovl_q;
    assign o_move_to_next_job = mtnj_q;
    assign o_move_forward     = mvf_q;
    assign o_stat_seq_cnt     = seq_cnt_q;
    assign o_stat_job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_lazy_select_pipeline.sv
// Scoreboard bench for lazy_select_pipeline: directed windows, backpressure,
// mid-flight reset and a random phase checked against a reference model.
module tb_lazy_select_pipeline;
    typedef struct packed {
        logic [4:0]       seq;
        logic [4:0]       match;
        logic             delim;
        logic             greedy;
        logic [7:0]       min_ml;
        logic [3:0]       v;
        logic [3:0][7:0]  ml;
        logic [3:0][15:0] off;
    } req_t;

    typedef struct packed {
        logic [4:0]  seq;
        logic [7:0]  ll;
        logic [7:0]  ml;
        logic [15:0] off;
        logic        nm;
        logic        delim;
        logic        eoj;
        logic        mtnj;
        logic [7:0]  ov;
        logic [4:0]  mf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_ready, o_valid;
    logic [4:0]  i_seq_head_ptr = '0, i_match_head_ptr = '0;
    logic        i_delim = 1'b0, i_greedy = 1'b0;
    logic [7:0]  i_min_ml = '0;
    logic [3:0]  i_match_valid = '0;
    logic [31:0] i_match_len = '0;
    logic [63:0] i_offset = '0;
    logic [4:0]  o_seq_head_ptr, o_move_forward;
    logic [7:0]  o_ll, o_ml, o_overlap_len;
    logic [15:0] o_offset;
    logic        o_nomatch, o_delim, o_eoj, o_move_to_next_job;
    logic [31:0] o_stat_seq_cnt, o_stat_job_cnt;

    lazy_select_pipeline dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_seq_head_ptr(i_seq_head_ptr), .i_match_head_ptr(i_match_head_ptr),
        .i_delim(i_delim), .i_greedy(i_greedy), .i_min_ml(i_min_ml),
        .i_match_valid(i_match_valid), .i_match_len(i_match_len), .i_offset(i_offset),
        .o_valid(o_valid), .i_ready(i_ready), .o_seq_head_ptr(o_seq_head_ptr),
        .o_ll(o_ll), .o_ml(o_ml), .o_offset(o_offset), .o_nomatch(o_nomatch),
        .o_delim(o_delim), .o_eoj(o_eoj), .o_overlap_len(o_overlap_len),
        .o_move_to_next_job(o_move_to_next_job), .o_move_forward(o_move_forward),
        .o_stat_seq_cnt(o_stat_seq_cnt), .o_stat_job_cnt(o_stat_job_cnt)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_seq   = 0;
    int   n_job   = 0;
    int   base_seq = 0;
    int   base_job = 0;
    logic rnd_rdy = 1'b0;
    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int seq, input int ll, input int ml, input int off,
                                    input logic nm, input logic delim, input logic eoj,
                                    input int ov, input int mf);
        exp_t e;
        e.seq = 5'(seq);  e.ll = 8'(ll);  e.ml = 8'(ml);  e.off = 16'(off);
        e.nm = nm;  e.delim = delim;  e.eoj = eoj;  e.mtnj = eoj;
        e.ov = 8'(ov);  e.mf = 5'(mf);
        return e;
    endfunction

    function automatic req_t base_req(input int seq, input int match);
        req_t r;
        r = '0;
        r.seq = 5'(seq);
        r.match = 5'(match);
        return r;
    endfunction

    // Reference model of the selection and job-end rules
    function automatic exp_t model(input req_t r);
        int best, bg, g, ob, ll, ml, off, mf, ov;
        logic nm;
        best = -1;  bg = 0;
        for (int i = 0; i < 4; i++) begin
            ob = 0;
            for (int b = 0; b < 16; b++) if (r.off[i][b]) ob = b + 1;
            g = 4 * int'(r.ml[i]) + 4 * (4 - i) - ob;
            if (r.v[i] && r.ml[i] >= r.min_ml && (!r.greedy || i == 0) && (best < 0 || g > bg)) begin
                best = i;
                bg = g;
            end
        end
        nm = (best < 0);
        if (nm) begin
            ll = 0;  ml = 0;  off = 0;
            mf = int'(r.match) - int'(r.seq) + 4;
        end else begin
            ll = int'(r.match) - int'(r.seq) + best;
            ml = int'(r.ml[best]);
            off = int'(r.off[best]);
            mf = ml + ll;
        end
        ov = int'(r.seq) + mf - 32;
        if (ov < 0)             return mk_exp(r.seq, ll, ml, off, nm, r.delim, 1'b0, 0, mf);
        else if (r.delim || nm) return mk_exp(r.seq, 32 - r.seq, 0, 0, nm, r.delim, 1'b1, 0, 0);
        else                    return mk_exp(r.seq, ll, ml, off, nm, r.delim, 1'b1, ov, 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input req_t r, input exp_t e);
        int   n;
        logic acc;
        n = 0;
        i_seq_head_ptr = r.seq;  i_match_head_ptr = r.match;
        i_delim = r.delim;  i_greedy = r.greedy;  i_min_ml = r.min_ml;
        i_match_valid = r.v;  i_match_len = r.ml;  i_offset = r.off;
        i_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = o_ready;
            step();
            n++;
        end while (!acc && n < 200);
        if (acc) sb.push_back(e);
        else     check_eq("accept_timeout", 64'(acc), 64'd1);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        check_eq("rst_seq_cnt", 64'(o_stat_seq_cnt), 64'd0);
        check_eq("rst_job_cnt", 64'(o_stat_job_cnt), 64'd0);
        sb.delete();
        repeat (2) step();
        rst_n = 1'b1;
        base_seq = n_seq;
        base_job = n_job;
    endtask

    // Output monitor: a transfer happens at the next rising edge
    always @(negedge clk) begin
        exp_t got, e;
        if (rst_n && o_valid && i_ready) begin
            got = {o_seq_head_ptr, o_ll, o_ml, o_offset, o_nomatch, o_delim, o_eoj,
                   o_move_to_next_job, o_overlap_len, o_move_forward};
            if (sb.size() == 0) begin
                check_eq("unexpected_out", 64'(got), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("out", 64'(got), 64'(e));
                if (!e.nm) n_seq++;
                if (e.eoj) n_job++;
            end
        end
    end

    initial begin
        req_t r;
        do_reset();

        r = base_req(0, 2);  r.v = 4'b0001;  r.ml[0] = 8'd6;  r.off[0] = 16'd5;
        send(r, mk_exp(0, 2, 6, 5, 1'b0, 1'b0, 1'b0, 0, 8));

        r = base_req(0, 0);  r.v = 4'b0011;
        r.ml[0] = 8'd4;  r.off[0] = 16'd1000;  r.ml[1] = 8'd6;  r.off[1] = 16'd3;
        send(r, mk_exp(0, 1, 6, 3, 1'b0, 1'b0, 1'b0, 0, 7));
        r.greedy = 1'b1;
        send(r, mk_exp(0, 0, 4, 1000, 1'b0, 1'b0, 1'b0, 0, 4));
        r.greedy = 1'b0;  r.min_ml = 8'd7;
        send(r, mk_exp(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 4));

        r = base_req(28, 28);  r.v = 4'b0001;  r.ml[0] = 8'd10;  r.off[0] = 16'd1;
        send(r, mk_exp(28, 0, 10, 1, 1'b0, 1'b0, 1'b1, 6, 0));
        r.delim = 1'b1;
        send(r, mk_exp(28, 4, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0));

        r = base_req(0, 0);  r.v = 4'b0011;
        r.ml[0] = 8'd4;  r.off[0] = 16'd3;  r.ml[1] = 8'd5;  r.off[1] = 16'd2;
        send(r, mk_exp(0, 0, 4, 3, 1'b0, 1'b0, 1'b0, 0, 4));

        r = base_req(30, 31);
        send(r, mk_exp(30, 2, 0, 0, 1'b1, 1'b0, 1'b1, 0, 0));

        r = base_req(4, 10);  r.v = 4'b0010;  r.ml[1] = 8'd9;  r.off[1] = 16'd7;  r.greedy = 1'b1;
        send(r, mk_exp(4, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 10));

        r = base_req(3, 5);  r.v = 4'b0001;  r.ml[0] = 8'd6;  r.min_ml = 8'd6;
        send(r, mk_exp(3, 2, 6, 0, 1'b0, 1'b0, 1'b0, 0, 8));
        drain();

        // Backpressure: three fill the pipe, the rest wait for release
        do_reset();
        i_ready = 1'b0;
        fork
            for (int k = 0; k < 6; k++) begin
                r = base_req(k, k + 1);  r.v = 4'b0001;
                r.ml[0] = 8'(k + 3);  r.off[0] = 16'(k + 1);
                send(r, mk_exp(k, 1, k + 3, k + 1, 1'b0, 1'b0, 1'b0, 0, k + 4));
            end
            begin
                repeat (10) @(posedge clk);
                #2;
                check_eq("bp_accepted", 64'(sb.size()), 64'd3);
                check_eq("bp_ready", 64'(o_ready), 64'd0);
                i_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_seq_cnt", 64'(o_stat_seq_cnt), 64'd6);
        check_eq("bp_job_cnt", 64'(o_stat_job_cnt), 64'd0);

        // Reset with two requests in flight, then check fill latency
        r = base_req(1, 3);  r.v = 4'b0001;  r.ml[0] = 8'd5;  r.off[0] = 16'd9;
        send(r, model(r));
        send(r, model(r));
        do_reset();
        r = base_req(2, 4);  r.v = 4'b0100;  r.ml[2] = 8'd12;  r.off[2] = 16'd300;
        send(r, model(r));
        check_eq("lat_e1", 64'(o_valid), 64'd0);
        step();
        check_eq("lat_e2", 64'(o_valid), 64'd0);
        step();
        check_eq("lat_e3", 64'(o_valid), 64'd1);
        drain();

        rnd_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int s;
            s = $urandom_range(0, 31);
            r = base_req(s, $urandom_range(s, 31));
            r.delim  = ($urandom_range(0, 3) == 0);
            r.greedy = ($urandom_range(0, 3) == 0);
            r.min_ml = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : 8'd0;
            for (int i = 0; i < 4; i++) begin
                r.v[i]   = 1'($urandom_range(0, 1));
                r.ml[i]  = 8'($urandom_range(0, 40));
                r.off[i] = 16'($urandom) >> $urandom_range(0, 16);
            end
            send(r, model(r));
        end
        drain();
        rnd_rdy = 1'b0;
        i_ready = 1'b1;
        check_eq("rnd_seq_cnt", 64'(o_stat_seq_cnt), 64'(n_seq - base_seq));
        check_eq("rnd_job_cnt", 64'(o_stat_job_cnt), 64'(n_job - base_job));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
